// File: rtl/fios_operand_sequencer_pkg.sv
// Shared types and constants for the FIOS operand sequencer.
package fios_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] LD_SEL_A   = 2'd0;
  localparam logic [1:0] LD_SEL_B   = 2'd1;
  localparam logic [1:0] LD_SEL_P   = 2'd2;
  localparam logic [1:0] LD_SEL_PP0 = 2'd3;

  localparam int unsigned ERR_LD_BUSY = 0;
  localparam int unsigned ERR_RES_CNT = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_W       = 3;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/fios_operand_sequencer_if.sv
// Link between the operand sequencer and the FIOS multiplier top.
interface fios_operand_sequencer_if #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned PE_NB      = 8
);
  logic                        fios_reset_o;
  logic                        fios_start_o;
  logic [WORD_WIDTH-1:0]       fios_pp0_o;
  logic [PE_NB*WORD_WIDTH-1:0] fios_a_o;
  logic [WORD_WIDTH-1:0]       fios_b_o;
  logic [WORD_WIDTH-1:0]       fios_p_o;
  logic                        fios_a_shift_i;
  logic                        fios_b_fetch_i;
  logic                        fios_p_fetch_i;
  logic                        fios_res_push_i;
  logic [WORD_WIDTH-1:0]       fios_res_i;
  logic                        fios_done_i;

  modport seq (
    output fios_reset_o, fios_start_o, fios_pp0_o, fios_a_o, fios_b_o, fios_p_o,
    input  fios_a_shift_i, fios_b_fetch_i, fios_p_fetch_i, fios_res_push_i,
           fios_res_i, fios_done_i
  );

  modport mult (
    input  fios_reset_o, fios_start_o, fios_pp0_o, fios_a_o, fios_b_o, fios_p_o,
    output fios_a_shift_i, fios_b_fetch_i, fios_p_fetch_i, fios_res_push_i,
           fios_res_i, fios_done_i
  );
endinterface

// File: rtl/fios_operand_sequencer_ram.sv
// Word storage: one write port, one registered read port, contents not reset.
module fios_word_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 17
) (
  input  logic                     clock_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fios_operand_sequencer.sv
// Host-side controller for the FIOS Montgomery multiplier: holds operands,
// launches one multiplication per command, serves fetches and collects results.
module fios_operand_sequencer
  import fios_seq_pkg::*;
#(
  parameter int unsigned S          = 8,
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned PE_NB      = 8,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  ld_we_i,
  input  logic [1:0]            ld_sel_i,
  input  logic [$clog2(S)-1:0]  ld_addr_i,
  input  logic [WORD_WIDTH-1:0] ld_data_i,
  input  logic                  cmd_start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ERR_W-1:0]      err_o,
  input  logic [$clog2(S)-1:0]  res_addr_i,
  output logic [WORD_WIDTH-1:0] res_data_o,
  fios_operand_sequencer_if.seq fios
);
  localparam int unsigned W   = WORD_WIDTH;
  localparam int unsigned AW  = $clog2(S);
  localparam int unsigned RW  = $clog2(S + 1);
  localparam int unsigned KN  = ceil_div(S, PE_NB);
  localparam int unsigned KW  = (KN > 1) ? $clog2(KN) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;
  logic launch_c, abort_c, timeout_c, done_c;
  logic ld_ok_c, ld_busy_c, push_ok_c, push_drop_c;

  logic [AW-1:0]    b_ptr_q, b_ptr_d, p_ptr_q, p_ptr_d;
  logic [KW-1:0]    k_q, k_d;
  logic [RW-1:0]    res_ptr_q, res_ptr_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [ERR_W-1:0] err_d;
  logic             fios_start_q, fios_reset_q;

  logic [W-1:0]       a_mem [S];
  logic [W-1:0]       pp0_q;
  logic [PE_NB*W-1:0] a_win_q, a_win_d;
  logic [W-1:0]       b_rd, p_rd;
  int unsigned        win_idx;

  // Next state; abort outranks done, done outranks the watchdog.
  always_comb begin
    state_d   = state_q;
    launch_c  = 1'b0;
    abort_c   = 1'b0;
    timeout_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start_i) begin
          state_d  = LAUNCH;
          launch_c = 1'b1;
        end
      end
      LAUNCH: begin
        if (abort_i) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          abort_c = 1'b1;
        end else if (fios.fios_done_i) begin
          state_d = DONE;
          done_c  = 1'b1;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        abort_c = abort_i;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer, watchdog and error-flag updates.
  always_comb begin
    ld_ok_c     = ld_we_i && (state_q == IDLE);
    ld_busy_c   = ld_we_i && (state_q != IDLE);
    push_ok_c   = fios.fios_res_push_i && (state_q == RUN) && (res_ptr_q < RW'(S));
    push_drop_c = fios.fios_res_push_i && (state_q == RUN) && (res_ptr_q >= RW'(S));

    b_ptr_d   = b_ptr_q;
    p_ptr_d   = p_ptr_q;
    k_d       = k_q;
    res_ptr_d = res_ptr_q;
    if (fios.fios_b_fetch_i) b_ptr_d = (b_ptr_q == AW'(S - 1)) ? '0 : b_ptr_q + AW'(1);
    if (fios.fios_p_fetch_i) p_ptr_d = (p_ptr_q == AW'(S - 1)) ? '0 : p_ptr_q + AW'(1);
    if (fios.fios_a_shift_i && (k_q != KW'(KN - 1))) k_d = k_q + KW'(1);
    if (push_ok_c) res_ptr_d = res_ptr_q + RW'(1);
    if (launch_c) begin
      b_ptr_d   = '0;
      p_ptr_d   = '0;
      k_d       = '0;
      res_ptr_d = '0;
    end

    wdog_d = (state_q == RUN) ? wdog_q + WDW'(1) : '0;

    err_d = launch_c ? '0 : err_o;
    err_d[ERR_LD_BUSY] = err_d[ERR_LD_BUSY] | ld_busy_c;
    err_d[ERR_RES_CNT] = err_d[ERR_RES_CNT] | push_drop_c | (done_c && (res_ptr_d != RW'(S)));
    err_d[ERR_TIMEOUT] = err_d[ERR_TIMEOUT] | timeout_c;
  end

  // A window for the next k; lanes past the last word read as zero.
  always_comb begin
    a_win_d = '0;
    win_idx = 0;
    for (int unsigned j = 0; j < PE_NB; j++) begin
      win_idx = 32'(k_d) * PE_NB + j;
      if (win_idx < S) a_win_d[j*W +: W] = a_mem[AW'(win_idx)];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= '0;
      fios_start_q <= 1'b0;
      fios_reset_q <= 1'b1;
      b_ptr_q      <= '0;
      p_ptr_q      <= '0;
      k_q          <= '0;
      res_ptr_q    <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_o       <= (state_d != IDLE);
      done_o       <= (state_d == DONE);
      err_o        <= err_d;
      fios_start_q <= (state_d == LAUNCH);
      fios_reset_q <= abort_c | timeout_c;
      b_ptr_q      <= b_ptr_d;
      p_ptr_q      <= p_ptr_d;
      k_q          <= k_d;
      res_ptr_q    <= res_ptr_d;
      wdog_q       <= wdog_d;
    end
  end

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clock_i) begin
    if (ld_ok_c && (ld_sel_i == LD_SEL_A))   a_mem[ld_addr_i] <= ld_data_i;
    if (ld_ok_c && (ld_sel_i == LD_SEL_PP0)) pp0_q <= ld_data_i;
    a_win_q <= a_win_d;
  end

  fios_word_ram #(.DEPTH(S), .WIDTH(W)) u_b_ram (
    .clock_i (clock_i),
    .we      (ld_ok_c && (ld_sel_i == LD_SEL_B)),
    .wr_addr (ld_addr_i),
    .wr_data (ld_data_i),
    .rd_addr (b_ptr_d),
    .rd_data (b_rd)
  );

  fios_word_ram #(.DEPTH(S), .WIDTH(W)) u_p_ram (
    .clock_i (clock_i),
    .we      (ld_ok_c && (ld_sel_i == LD_SEL_P)),
    .wr_addr (ld_addr_i),
    .wr_data (ld_data_i),
    .rd_addr (p_ptr_d),
    .rd_data (p_rd)
  );

  fios_word_ram #(.DEPTH(S), .WIDTH(W)) u_res_ram (
    .clock_i (clock_i),
    .we      (push_ok_c),
    .wr_addr (res_ptr_q[AW-1:0]),
    .wr_data (fios.fios_res_i),
    .rd_addr (res_addr_i),
    .rd_data (res_data_o)
  );

  assign fios.fios_reset_o = fios_reset_q;
  assign fios.fios_start_o = fios_start_q;
  assign fios.fios_pp0_o   = pp0_q;
  assign fios.fios_a_o     = a_win_q;
  assign fios.fios_b_o     = b_rd;
  assign fios.fios_p_o     = p_rd;
endmodule

// File: tb/tb_fios_operand_sequencer.sv
// Scoreboard bench for fios_operand_sequencer in EXPAND (PE_NB=8) and FOLD (PE_NB=3) form.
module tb_fios_operand_sequencer;
  import fios_seq_pkg::*;

  localparam int unsigned S   = 8;
  localparam int unsigned W   = 17;
  localparam int unsigned PE  = 8;
  localparam int unsigned PEF = 3;
  localparam int unsigned TO  = 64;

  logic clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  logic         reset_i, ld_we, cmd_start, abort;
  logic [1:0]   ld_sel;
  logic [2:0]   ld_addr, res_addr;
  logic [W-1:0] ld_data;
  logic         busy, done, f_busy, f_done;
  logic [2:0]   err, f_err;
  logic [W-1:0] res_data, f_res_data;

  fios_operand_sequencer_if #(.WORD_WIDTH(W), .PE_NB(PE))  m ();
  fios_operand_sequencer_if #(.WORD_WIDTH(W), .PE_NB(PEF)) f ();

  fios_operand_sequencer #(.S(S), .WORD_WIDTH(W), .PE_NB(PE), .TIMEOUT(TO)) u_dut (
    .clock_i(clock_i), .reset_i(reset_i), .ld_we_i(ld_we), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .cmd_start_i(cmd_start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err), .res_addr_i(res_addr),
    .res_data_o(res_data), .fios(m)
  );

  fios_operand_sequencer #(.S(S), .WORD_WIDTH(W), .PE_NB(PEF), .TIMEOUT(TO)) u_fold (
    .clock_i(clock_i), .reset_i(reset_i), .ld_we_i(ld_we), .ld_sel_i(ld_sel),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data), .cmd_start_i(cmd_start), .abort_i(abort),
    .busy_o(f_busy), .done_o(f_done), .err_o(f_err), .res_addr_i(res_addr),
    .res_data_o(f_res_data), .fios(f)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0]     q_word [$];
  logic [PEF*W-1:0] q_win  [$];

  task automatic tick();
    @(negedge clock_i);
  endtask

  task automatic load(input logic [1:0] sel, input int addr, input int data);
    ld_we = 1'b1; ld_sel = sel; ld_addr = 3'(addr); ld_data = W'(data);
    tick();
    ld_we = 1'b0;
  endtask

  task automatic start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  function automatic logic [PEF*W-1:0] fold_win(input int k);
    logic [PEF*W-1:0] v;
    v = '0;
    for (int j = 0; j < PEF; j++)
      if (k * PEF + j < S) v[j*W +: W] = W'(k * PEF + j + 1);
    return v;
  endfunction

  task automatic push_and_done(input int n, input int base, input bit coincide);
    for (int i = 0; i < n; i++) begin
      m.fios_res_push_i = 1'b1;
      m.fios_res_i      = W'(base + i);
      if (i < S) q_word.push_back(W'(base + i));
      m.fios_done_i     = coincide && (i == n - 1);
      tick();
    end
    m.fios_res_push_i = 1'b0;
    if (!coincide) begin
      m.fios_done_i = 1'b1;
      tick();
    end
    m.fios_done_i = 1'b0;
  endtask

  task automatic read_back(input string tag);
    int n;
    logic [W-1:0] exp;
    n = q_word.size();
    for (int i = 0; i < n; i++) begin
      res_addr = 3'(i);
      tick();
      exp = q_word.pop_front();
      checks++;
      if (res_data !== exp) begin
        errors++;
        $display("FAIL %s_res[%0d] got %h want %h", tag, i, res_data, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    checks++; if (m.fios_reset_o !== 1'b1) begin errors++; $display("FAIL reset_fios_reset got %b want 1", m.fios_reset_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL reset_err got %b want 000", err); end
    checks++; if (m.fios_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", m.fios_start_o); end
    reset_i = 1'b0;
    tick();
    checks++; if (m.fios_reset_o !== 1'b0) begin errors++; $display("FAIL release_fios_reset got %b want 0", m.fios_reset_o); end
  endtask

  task automatic test_load_start();
    for (int i = 0; i < S; i++) begin
      load(LD_SEL_A, i, i + 1);
      load(LD_SEL_B, i, i + 1);
      load(LD_SEL_P, i, i + 1);
    end
    load(LD_SEL_PP0, 0, 5);
    tick();
    start();
    checks++; if (m.fios_start_o !== 1'b1) begin errors++; $display("FAIL launch_start got %b want 1", m.fios_start_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL launch_busy got %b want 1", busy); end
    checks++; if (m.fios_pp0_o !== W'(5)) begin errors++; $display("FAIL launch_pp0 got %0d want 5", m.fios_pp0_o); end
    checks++; if (m.fios_a_o[W-1:0] !== W'(1)) begin errors++; $display("FAIL launch_a_lane0 got %0d want 1", m.fios_a_o[W-1:0]); end
    checks++; if (m.fios_b_o !== W'(1)) begin errors++; $display("FAIL launch_b got %0d want 1", m.fios_b_o); end
    tick();
    checks++; if (m.fios_start_o !== 1'b0) begin errors++; $display("FAIL run_start got %b want 0", m.fios_start_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", busy); end
  endtask

  task automatic test_fetch();
    int bp;
    logic [W-1:0] exp;
    bp = 0;
    for (int i = 0; i < 11; i++) begin
      m.fios_b_fetch_i = 1'b1;
      m.fios_p_fetch_i = (i < 3);
      bp = (bp + 1) % S;
      q_word.push_back(W'(bp + 1));
      tick();
      exp = q_word.pop_front();
      checks++; if (m.fios_b_o !== exp) begin errors++; $display("FAIL b_fetch[%0d] got %0d want %0d", i, m.fios_b_o, exp); end
      if (i < 3) begin
        checks++; if (m.fios_p_o !== W'(i + 2)) begin errors++; $display("FAIL p_fetch[%0d] got %0d want %0d", i, m.fios_p_o, i + 2); end
      end
    end
    m.fios_b_fetch_i = 1'b0;
    m.fios_p_fetch_i = 1'b0;
    tick();
    checks++; if (m.fios_b_o !== W'(4)) begin errors++; $display("FAIL b_hold got %0d want 4", m.fios_b_o); end
    checks++; if (m.fios_p_o !== W'(4)) begin errors++; $display("FAIL p_hold got %0d want 4", m.fios_p_o); end
  endtask

  task automatic test_fold_shift();
    int k;
    logic [PEF*W-1:0] exp;
    k = 0;
    checks++; if (f.fios_a_o !== fold_win(0)) begin errors++; $display("FAIL fold_k0 got %h want %h", f.fios_a_o, fold_win(0)); end
    for (int i = 0; i < 3; i++) begin
      f.fios_a_shift_i = 1'b1;
      m.fios_a_shift_i = (i == 0);
      if (k < 2) k++;
      q_win.push_back(fold_win(k));
      tick();
      exp = q_win.pop_front();
      checks++; if (f.fios_a_o !== exp) begin errors++; $display("FAIL fold_shift[%0d] got %h want %h", i, f.fios_a_o, exp); end
    end
    f.fios_a_shift_i = 1'b0;
    m.fios_a_shift_i = 1'b0;
    checks++; if (m.fios_a_o[W-1:0] !== W'(1)) begin errors++; $display("FAIL expand_shift_sat got %0d want 1", m.fios_a_o[W-1:0]); end
    f.fios_done_i = 1'b1;
    tick();
    f.fios_done_i = 1'b0;
    checks++; if (f_done !== 1'b1) begin errors++; $display("FAIL fold_done got %b want 1", f_done); end
    checks++; if (f_err[ERR_RES_CNT] !== 1'b1) begin errors++; $display("FAIL fold_short_err got %b want 1", f_err[ERR_RES_CNT]); end
    tick();
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fold_idle_busy got %b want 0", f_busy); end
  endtask

  task automatic check_done(input string tag, input logic [2:0] exp_err);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", tag, done); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL %s_err got %b want %b", tag, err, exp_err); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle_busy got %b want 0", tag, busy); end
  endtask

  task automatic test_results();
    push_and_done(8, 'hA0, 1'b1);
    check_done("res8", 3'b000);
    read_back("res8");
  endtask

  task automatic test_overflow();
    start();
    tick();
    push_and_done(9, 'hB0, 1'b0);
    check_done("res9", 3'b010);
    read_back("res9");
  endtask

  task automatic test_short_and_busy_load();
    start();
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL err_clear_on_start got %b want 000", err); end
    tick();
    load(LD_SEL_A, 0, 'h1FFFF);
    checks++; if (err !== 3'b001) begin errors++; $display("FAIL ld_busy_err got %b want 001", err); end
    push_and_done(6, 'hC0, 1'b0);
    check_done("res6", 3'b011);
    tick();
    checks++; if (m.fios_a_o[W-1:0] !== W'(1)) begin errors++; $display("FAIL ld_busy_dropped got %h want 1", m.fios_a_o[W-1:0]); end
    read_back("res6");
  endtask

  task automatic test_timeout();
    int n;
    bit seen_done;
    n = 0;
    seen_done = 1'b0;
    start();
    while (m.fios_reset_o !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++; if (n != TO + 1) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", n, TO + 1); end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL timeout_no_done got %b want 0", seen_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
    checks++; if (err !== 3'b100) begin errors++; $display("FAIL timeout_err got %b want 100", err); end
    tick();
    checks++; if (m.fios_reset_o !== 1'b0) begin errors++; $display("FAIL timeout_reset_pulse got %b want 0", m.fios_reset_o); end
  endtask

  task automatic test_abort();
    start();
    tick();
    tick();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checks++; if (m.fios_start_o !== 1'b0) begin errors++; $display("FAIL start_ignored got %b want 0", m.fios_start_o); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL start_ignored_err got %b want 000", err); end
    abort = 1'b1;
    m.fios_done_i = 1'b1;
    tick();
    abort = 1'b0;
    m.fios_done_i = 1'b0;
    checks++; if (m.fios_reset_o !== 1'b1) begin errors++; $display("FAIL abort_reset got %b want 1", m.fios_reset_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL abort_err got %b want 000", err); end
    tick();
    checks++; if (m.fios_reset_o !== 1'b0) begin errors++; $display("FAIL abort_reset_pulse got %b want 0", m.fios_reset_o); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_late_done got %b want 0", done); end
  endtask

  task automatic test_reset_mid();
    start();
    tick();
    reset_i = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (m.fios_reset_o !== 1'b1) begin errors++; $display("FAIL midreset_fios_reset got %b want 1", m.fios_reset_o); end
    reset_i = 1'b0;
    tick();
    checks++; if (m.fios_reset_o !== 1'b0) begin errors++; $display("FAIL midreset_release got %b want 0", m.fios_reset_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got %b want 0", busy); end
  endtask

  initial begin
    reset_i = 1'b1; ld_we = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
    cmd_start = 1'b0; abort = 1'b0; res_addr = '0;
    m.fios_a_shift_i = 1'b0; m.fios_b_fetch_i = 1'b0; m.fios_p_fetch_i = 1'b0;
    m.fios_res_push_i = 1'b0; m.fios_res_i = '0; m.fios_done_i = 1'b0;
    f.fios_a_shift_i = 1'b0; f.fios_b_fetch_i = 1'b0; f.fios_p_fetch_i = 1'b0;
    f.fios_res_push_i = 1'b0; f.fios_res_i = '0; f.fios_done_i = 1'b0;
    test_reset();
    test_load_start();
    test_fetch();
    test_fold_shift();
    test_results();
    test_overflow();
    test_short_and_busy_load();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end
endmodule
